// File: rtl/ecg_frame_buffer.sv
// ecg_frame_buffer: ping-pong double buffer that gathers channel-interleaved
// ECG readings into N_CH x N_SAMP frames and presents each finished frame as
// a parallel matrix. One bank fills while the other is held for the consumer.
module ecg_frame_buffer #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned N_SAMP    = 8,
    parameter int unsigned N_BITS    = 22,
    parameter int unsigned FCNT_BITS = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [N_BITS-1:0]                         in_data,
    input  logic                                      in_first,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [N_CH-1:0][N_SAMP-1:0][N_BITS-1:0]   mat_out,
    output logic [FCNT_BITS-1:0]                      frame_cnt,
    output logic                                      sync_err
);

    localparam int unsigned CW = (N_CH   > 1) ? $clog2(N_CH)   : 1;
    localparam int unsigned SW = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;

    logic [1:0][N_CH-1:0][N_SAMP-1:0][N_BITS-1:0] bank;
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] ch_ptr;
    logic [SW-1:0] samp_ptr;

    logic          accept;
    logic          resync;
    logic          rel;
    logic          last_ch;
    logic          last_samp;
    logic [CW-1:0] wr_ch;
    logic [SW-1:0] wr_samp;

    // Handshake qualifiers, effective write position and presented bank.
    // A mid-frame in_first redirects the write to (0,0) so the partial frame
    // is simply overwritten; pointer advance then proceeds from that position.
    always_comb begin
        in_ready  = rst_n & ~full[wr_bank];
        out_valid = full[rd_bank];
        mat_out   = bank[rd_bank];
        accept    = in_valid & in_ready;
        rel       = out_valid & out_ready;
        resync    = in_first & ((ch_ptr != '0) | (samp_ptr != '0));
        wr_ch     = resync ? '0 : ch_ptr;
        wr_samp   = resync ? '0 : samp_ptr;
        last_ch   = (wr_ch   == CW'(N_CH - 1));
        last_samp = (wr_samp == SW'(N_SAMP - 1));
    end

    // Bank storage, pointers, bank ownership, frame counter and sync flag.
    // Completion and release always touch different full[] bits, so both may
    // take effect on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank      <= '0;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            ch_ptr    <= '0;
            samp_ptr  <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
        end else begin
            if (accept) begin
                bank[wr_bank][wr_ch][wr_samp] <= in_data;
                if (resync) begin
                    sync_err <= 1'b1;
                end
                if (last_ch) begin
                    ch_ptr <= '0;
                    if (last_samp) begin
                        samp_ptr      <= '0;
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                    end else begin
                        samp_ptr <= wr_samp + 1'b1;
                    end
                end else begin
                    ch_ptr   <= wr_ch + 1'b1;
                    samp_ptr <= wr_samp;
                end
            end
            if (rel) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_cnt     <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecg_frame_buffer.sv
// Directed testbench for ecg_frame_buffer with a frame scoreboard. Two
// instances share all inputs; the second uses a 4-bit frame counter.
module tb_ecg_frame_buffer;

    typedef logic [7:0][7:0][21:0] frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_first;
    logic        out_ready;
    logic [21:0] in_data;

    logic        in_ready,  out_valid,  sync_err;
    frame_t      mat_out;
    logic [15:0] frame_cnt;
    logic        in_ready4, out_valid4, sync_err4;
    frame_t      mat_out4;
    logic [3:0]  frame_cnt4;

    int     total = 0;
    int     bad   = 0;
    frame_t sbq[$];
    int     cnt;
    frame_t cur;
    int     mch;
    int     ms;
    logic   sync_exp;

    always #5 clk = ~clk;

    ecg_frame_buffer #(.N_CH(8), .N_SAMP(8), .N_BITS(22), .FCNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first), .out_valid(out_valid),
        .out_ready(out_ready), .mat_out(mat_out), .frame_cnt(frame_cnt),
        .sync_err(sync_err)
    );

    ecg_frame_buffer #(.N_CH(8), .N_SAMP(8), .N_BITS(22), .FCNT_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_first(in_first), .out_valid(out_valid4),
        .out_ready(out_ready), .mat_out(mat_out4), .frame_cnt(frame_cnt4),
        .sync_err(sync_err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
        int fc = 0;
        int fs = 0;
        total++;
        assert (obs === exp) else begin
            bad++;
            for (int c = 7; c >= 0; c--)
                for (int s = 7; s >= 0; s--)
                    if (obs[c][s] !== exp[c][s]) begin
                        fc = c;
                        fs = s;
                    end
            $error("FAIL %s [%0d][%0d] observed=%0h expected=%0h",
                   tag, fc, fs, obs[fc][fs], exp[fc][fs]);
        end
    endtask

    // Drive one reading and wait (bounded) for it to be accepted; update model.
    task automatic send(input logic [21:0] d, input logic f);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        if (f && (mch != 0 || ms != 0)) begin
            mch      = 0;
            ms       = 0;
            sync_exp = 1'b1;
        end
        cur[mch][ms] = d;
        mch++;
        if (mch == 8) begin
            mch = 0;
            ms++;
            if (ms == 8) begin
                ms = 0;
                sbq.push_back(cur);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((out_valid || sbq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out_valid", out_valid, 0);
        chk("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk_frame("rst_mat_out", mat_out, '0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_frame_cnt4", frame_cnt4, 0);
        chk("rst_sync_err", sync_err, 0);
        sbq.delete();
        cnt      = 0;
        mch      = 0;
        ms       = 0;
        sync_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    // Scoreboard: on every handshake compare the presented frame and counters.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_has_frame", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                chk_frame("sb_frame", mat_out, sbq[0]);
                chk_frame("sb_frame4", mat_out4, sbq[0]);
                chk("sb_frame_cnt", frame_cnt, 64'(cnt[15:0]));
                chk("sb_frame_cnt4", frame_cnt4, 64'(cnt[3:0]));
                void'(sbq.pop_front());
                cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cnt       = 0;
        mch       = 0;
        ms        = 0;
        sync_exp  = 1'b0;
        cur       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("init_in_ready", in_ready, 0);
        chk("init_out_valid", out_valid, 0);
        chk_frame("init_mat_out", mat_out, '0);
        chk("init_frame_cnt", frame_cnt, 0);
        chk("init_sync_err", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_in_ready_up", in_ready, 1);

        // 1: single frame 1..64 with the consumer ready
        out_ready = 1'b1;
        for (int v = 1; v <= 64; v++) send(22'(v), v == 1);
        chk("t1_out_valid", out_valid, 1);
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 8; s++)
                e[c][s] = 22'(1 + 8 * s + c);
        chk_frame("t1_layout", mat_out, e);
        @(posedge clk);
        #1;
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_out_valid_low", out_valid, 0);
        chk("t1_sync_err", sync_err, 0);

        // 2: consumer stalled, both banks fill, single-cycle release
        out_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(22'(1000 + i), (i % 64) == 0);
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_f1_elem", mat_out[0][0], 1000);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_elem", mat_out[7][7], 1063);
        chk("t2_hold_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t2_f2_elem", mat_out[0][0], 1064);
        chk_frame("t2_f2_frame", mat_out, sbq[0]);
        chk("t2_in_ready_reopen", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(22'(2000 + i), i == 0);
        drain();
        chk("t2_frame_cnt", frame_cnt, 4);

        // 3: in_first mid-frame resynchronises
        for (int i = 0; i < 10; i++) send(22'(3000 + i), i == 0);
        send(22'h3FFFFF, 1'b1);
        for (int i = 0; i < 63; i++) send(22'(3100 + i), 1'b0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_elem00", mat_out[0][0], 22'h3FFFFF);
        chk("t3_elem10", mat_out[1][0], 3100);
        chk("t3_sync_err", sync_err, 1);
        chk("t3_sync_model", sync_err, sync_exp);
        drain();
        chk("t3_frame_cnt", frame_cnt, 5);

        // 4: reset mid-frame drops the partial frame
        for (int i = 0; i < 20; i++) send(22'(4000 + i), i == 0);
        do_reset();
        for (int i = 0; i < 64; i++) send(22'(5000 + i), i == 0);
        drain();
        chk("t4_frame_cnt", frame_cnt, 1);
        chk("t4_sync_err", sync_err, 0);

        // 5: completion of B on the same edge as the release of A
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(22'(6000 + i), i == 0);
        for (int i = 0; i < 63; i++) send(22'(7000 + i), i == 0);
        out_ready = 1'b1;
        send(22'(7063), 1'b0);
        out_ready = 1'b0;
        chk("t5_out_valid", out_valid, 1);
        chk("t5_elem00", mat_out[0][0], 7000);
        chk("t5_frame_cnt", frame_cnt, 2);
        @(posedge clk);
        #1;
        chk("t5_frame_cnt_once", frame_cnt, 2);
        chk("t5_hold_elem", mat_out[7][7], 7063);
        out_ready = 1'b1;
        drain();
        chk("t5_frame_cnt_end", frame_cnt, 3);

        // 6: all-ones data, 17 frames, narrow counter wraps
        do_reset();
        for (int f = 0; f < 17; f++)
            for (int i = 0; i < 64; i++) send(22'h3FFFFF, i == 0);
        drain();
        chk("t6_frame_cnt4", frame_cnt4, 1);
        chk("t6_frame_cnt", frame_cnt, 17);
        chk("t6_sync_err4", sync_err4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
